serial_comparator: RTL

- Parametrised, multi-cycle magnitude/equality comparator for the ALU datapath; next generation of the 32-bit single-cycle not-equal detector.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, in signed or unsigned mode.
- Produces isNotEqual and isLessThan behind valid/ready handshakes on both input and output.
- Trades latency for a narrow compare path; sits beside the adder/subtractor in the ALU.

---
 rtl/serial_comparator_pkg.sv | 15 +
 rtl/chunk_compare.sv | 23 ++
 rtl/serial_comparator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_comparator_pkg.sv
// Shared types and helpers for the serial magnitude/equality comparator.
// State encoding plus the chunk-count helper used to size the scan.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// One-chunk unsigned compare with optional MSB flip for signed top chunk.
// Flipping the sign bit maps two's-complement order onto unsigned order.
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             neq,
  output logic             lt
);

  logic [CHUNK-1:0] msb_mask;
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  assign msb_mask = CHUNK'(invert_msb) << (CHUNK - 1);
  assign a_x      = a ^ msb_mask;
  assign b_x      = b ^ msb_mask;
  assign neq      = (a_x != b_x);
  assign lt       = (a_x < b_x);

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle comparator: scans CHUNK bits per cycle, MSB chunk first.
// SERIAL_COMPARATOR_EARLY_EXIT_EN: stop at first differing chunk.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             isNotEqual,
  output logic             isLessThan
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sgn;
  logic [IDXW-1:0]  idx;
  logic [CHUNK-1:0] cur_a;
  logic [CHUNK-1:0] cur_b;
  logic             c_neq;
  logic             c_lt;
  logic             msb_sel;
  logic             accept;
  logic             last;
  logic             finish;
`ifndef SERIAL_COMPARATOR_EARLY_EXIT_EN
  logic             decided;
`endif

  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign last     = (idx == '0);
  assign msb_sel  = sgn && (idx == IDX_TOP);

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  assign finish = c_neq || last;
`else
  assign finish = last;
`endif

  // Select the chunk under inspection this cycle.
  always_comb begin
    cur_a = op_a[int'(idx)*CHUNK +: CHUNK];
    cur_b = op_b[int'(idx)*CHUNK +: CHUNK];
  end

  chunk_compare #(
    .CHUNK(CHUNK)
  ) u_cmp (
    .a          (cur_a),
    .b          (cur_b),
    .invert_msb (msb_sel),
    .neq        (c_neq),
    .lt         (c_lt)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (finish) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, chunk index and result flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a       <= '0;
      op_b       <= '0;
      sgn        <= 1'b0;
      idx        <= '0;
      isNotEqual <= 1'b0;
      isLessThan <= 1'b0;
`ifndef SERIAL_COMPARATOR_EARLY_EXIT_EN
      decided    <= 1'b0;
`endif
    end else if (accept) begin
      op_a       <= data_operandA;
      op_b       <= data_operandB;
      sgn        <= ctrl_signed;
      idx        <= IDX_TOP;
      isNotEqual <= 1'b0;
      isLessThan <= 1'b0;
`ifndef SERIAL_COMPARATOR_EARLY_EXIT_EN
      decided    <= 1'b0;
`endif
    end else if (state_q == BUSY) begin
      if (!last) idx <= idx - 1'b1;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
      if (c_neq) begin
        isNotEqual <= 1'b1;
        isLessThan <= c_lt;
      end
`else
      if (c_neq && !decided) begin
        isNotEqual <= 1'b1;
        isLessThan <= c_lt;
        decided    <= 1'b1;
      end
`endif
    end
  end

  // Result valid rises one cycle into DONE, drops on handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 out_valid <= 1'b0;
    else if (state_q == DONE)  out_valid <= !(out_valid && out_ready);
    else                       out_valid <= 1'b0;
  end

endmodule
